// File: rtl/dht_fmt_pkg.sv
// Shared constants, FSM state type and line-geometry helpers for the DHT line formatter.
package dht_fmt_pkg;

    localparam logic [7:0] ASC_T     = 8'h74;
    localparam logic [7:0] ASC_E     = 8'h65;
    localparam logic [7:0] ASC_M     = 8'h6D;
    localparam logic [7:0] ASC_P     = 8'h70;
    localparam logic [7:0] ASC_H     = 8'h68;
    localparam logic [7:0] ASC_U     = 8'h75;
    localparam logic [7:0] ASC_I     = 8'h69;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_DOT   = 8'h2E;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_O     = 8'h4F;
    localparam logic [7:0] ASC_K     = 8'h4B;
    localparam logic [7:0] ASC_X     = 8'h58;
    localparam logic [7:0] ASC_QM    = 8'h3F;
    localparam logic [7:0] ASC_0     = 8'h30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned line_len(input int unsigned int_digits,
                                             input int unsigned frac_digits);
        return 18 + 2 * int_digits + 4 * frac_digits;
    endfunction

    // Characters of the six-byte "temp: " / "humi: " field labels.
    function automatic logic [7:0] label_char(input logic [2:0] pos, input logic humi);
        logic [7:0] c;
        c = ASC_SP;
        case (pos)
            3'd0:    c = humi ? ASC_H : ASC_T;
            3'd1:    c = humi ? ASC_U : ASC_E;
            3'd2:    c = ASC_M;
            3'd3:    c = humi ? ASC_I : ASC_P;
            3'd4:    c = ASC_COLON;
            default: c = ASC_SP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bcd_to_ascii.sv
// One BCD nibble to its ASCII digit; nibbles A..F render as '?'.
module bcd_to_ascii
    import dht_fmt_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_c_o
);

    always_comb begin
        ascii_c_o = ASC_QM;
        if (nibble_i <= 4'd9) begin
            ascii_c_o = ASC_0 + {4'h0, nibble_i};
        end
    end

endmodule

// File: rtl/dht_line_formatter.sv
// Snapshots DHT readings on i_start and streams one ASCII status line over valid/ready.
// Optional build macro DHT_FMT_ZERO_SUPPRESS_EN blanks leading zero integer digits.
module dht_line_formatter
    import dht_fmt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned INT_DIGITS  = 2,
    parameter int unsigned FRAC_DIGITS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_error,
    input  logic [4*INT_DIGITS-1:0] i_temp_int,
    input  logic [3:0]              i_temp_frac,
    input  logic [4*INT_DIGITS-1:0] i_humi_int,
    input  logic [3:0]              i_humi_frac,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int unsigned IW       = 4 * INT_DIGITS;
    localparam int unsigned LINE_LEN = line_len(INT_DIGITS, FRAC_DIGITS);
    localparam int unsigned IDX_W    = $clog2(LINE_LEN);
    localparam int unsigned T_INT    = 6;
    localparam int unsigned T_DOT    = T_INT + INT_DIGITS;
    localparam int unsigned T_FRC    = T_DOT + 1;
    localparam int unsigned T_SP     = T_INT + INT_DIGITS + 2 * FRAC_DIGITS;
    localparam int unsigned H_LBL    = T_SP + 1;
    localparam int unsigned H_INT    = H_LBL + 6;
    localparam int unsigned H_DOT    = H_INT + INT_DIGITS;
    localparam int unsigned H_FRC    = H_DOT + 1;
    localparam int unsigned TAB_POS  = H_INT + INT_DIGITS + 2 * FRAC_DIGITS;
    localparam int unsigned ST0_POS  = TAB_POS + 1;
    localparam int unsigned ST1_POS  = TAB_POS + 2;
    localparam int unsigned CR_POS   = TAB_POS + 3;
    localparam int unsigned LF_POS   = TAB_POS + 4;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [IW-1:0]           t_int_q, h_int_q;
    logic [3:0]              t_frac_q, h_frac_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   data_d;
    logic                    valid_d, busy_d, done_d;
    logic [7:0]              char_c;
    logic [7:0]              t_asc [INT_DIGITS];
    logic [7:0]              h_asc [INT_DIGITS];
    logic [7:0]              t_chr [INT_DIGITS];
    logic [7:0]              h_chr [INT_DIGITS];
    logic [7:0]              t_frac_asc, h_frac_asc;

    for (genvar k = 0; k < INT_DIGITS; k++) begin : g_dig
        bcd_to_ascii u_t (.nibble_i(t_int_q[4*k +: 4]), .ascii_c_o(t_asc[k]));
        bcd_to_ascii u_h (.nibble_i(h_int_q[4*k +: 4]), .ascii_c_o(h_asc[k]));
    end
    bcd_to_ascii u_tf (.nibble_i(t_frac_q), .ascii_c_o(t_frac_asc));
    bcd_to_ascii u_hf (.nibble_i(h_frac_q), .ascii_c_o(h_frac_asc));

`ifdef DHT_FMT_ZERO_SUPPRESS_EN
    // Blank zeros from the MSD down until the first nonzero nibble; digit 0 always prints.
    always_comb begin
        logic t_lead, h_lead;
        t_lead = 1'b1;
        h_lead = 1'b1;
        for (int k = 0; k < int'(INT_DIGITS); k++) begin
            t_chr[k] = t_asc[k];
            h_chr[k] = h_asc[k];
        end
        for (int k = int'(INT_DIGITS) - 1; k > 0; k--) begin
            t_lead = t_lead && (t_int_q[4*k +: 4] == 4'd0);
            h_lead = h_lead && (h_int_q[4*k +: 4] == 4'd0);
            if (t_lead) t_chr[k] = ASC_SP;
            if (h_lead) h_chr[k] = ASC_SP;
        end
    end
`else
    always_comb begin
        for (int k = 0; k < int'(INT_DIGITS); k++) begin
            t_chr[k] = t_asc[k];
            h_chr[k] = h_asc[k];
        end
    end
`endif

    // Character for the byte position that will be presented next.
    always_comb begin
        char_c = 8'h00;
        case (index_d)
            IDX_W'(T_SP):    char_c = ASC_SP;
            IDX_W'(TAB_POS): char_c = ASC_TAB;
            IDX_W'(ST0_POS): char_c = err_q ? ASC_X : ASC_O;
            IDX_W'(ST1_POS): char_c = err_q ? ASC_X : ASC_K;
            IDX_W'(CR_POS):  char_c = ASC_CR;
            IDX_W'(LF_POS):  char_c = ASC_LF;
            default: begin
                if (index_d < IDX_W'(T_INT)) begin
                    char_c = label_char(3'(index_d), 1'b0);
                end else if (index_d >= IDX_W'(H_LBL) && index_d < IDX_W'(H_INT)) begin
                    char_c = label_char(3'(index_d - IDX_W'(H_LBL)), 1'b1);
                end
                for (int k = 0; k < int'(INT_DIGITS); k++) begin
                    if (index_d == IDX_W'(int'(T_INT + INT_DIGITS) - 1 - k)) char_c = t_chr[k];
                    if (index_d == IDX_W'(int'(H_INT + INT_DIGITS) - 1 - k)) char_c = h_chr[k];
                end
                if (FRAC_DIGITS != 0) begin
                    if (index_d == IDX_W'(T_DOT)) char_c = ASC_DOT;
                    if (index_d == IDX_W'(T_FRC)) char_c = t_frac_asc;
                    if (index_d == IDX_W'(H_DOT)) char_c = ASC_DOT;
                    if (index_d == IDX_W'(H_FRC)) char_c = h_frac_asc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = SEND;
                    index_d = '0;
                end
            end
            SEND: begin
                if (i_ready) begin
                    if (index_q == IDX_W'(LF_POS)) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                index_d = '0;
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so o_valid rises the cycle after start.
    always_comb begin
        valid_d = (state_d == SEND);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        data_d  = '0;
        if (valid_d) data_d = DATA_WIDTH'(char_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_data  <= data_d;
            o_valid <= valid_d;
            o_busy  <= busy_d;
            o_done  <= done_d;
        end
    end

    // Snapshot taken only when a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_int_q  <= '0;
            h_int_q  <= '0;
            t_frac_q <= '0;
            h_frac_q <= '0;
            err_q    <= 1'b0;
        end else if (state_q == IDLE && i_start) begin
            t_int_q  <= i_temp_int;
            h_int_q  <= i_humi_int;
            t_frac_q <= i_temp_frac;
            h_frac_q <= i_humi_frac;
            err_q    <= i_error;
        end
    end

endmodule

// File: tb/tb_dht_line_formatter.sv
// Scoreboard bench: default-geometry instance plus a 3-integer-digit, no-fraction, 12-bit instance.
module tb_dht_line_formatter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic        ready = 1'b1;
    logic        err = 1'b0;
    logic [11:0] tint = '0;
    logic [11:0] hum_int = '0;
    logic [3:0]  tf = '0;
    logic [3:0]  hf = '0;

    logic [7:0]  a_data;
    logic [11:0] b_data;
    logic        a_valid, a_busy, a_done, b_valid, b_busy, b_done;
    logic [11:0] m_data;
    logic        m_valid, m_busy, m_done;

    int          n_err = 0;
    int          n_chk = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          nbytes = 0;
    int          rise_cyc = 0;
    int          lf_cyc = 0;
    logic [11:0] exp_q [$];
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
    logic [11:0] prev_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dht_line_formatter u_a (
        .clk(clk), .rst_n(rst_n), .i_start(start & ~sel), .i_error(err),
        .i_temp_int(tint[7:0]), .i_temp_frac(tf), .i_humi_int(hum_int[7:0]), .i_humi_frac(hf),
        .o_data(a_data), .o_valid(a_valid), .i_ready(ready), .o_busy(a_busy), .o_done(a_done)
    );

    dht_line_formatter #(.DATA_WIDTH(12), .INT_DIGITS(3), .FRAC_DIGITS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .i_start(start & sel), .i_error(err),
        .i_temp_int(tint), .i_temp_frac(tf), .i_humi_int(hum_int), .i_humi_frac(hf),
        .o_data(b_data), .o_valid(b_valid), .i_ready(ready), .o_busy(b_busy), .o_done(b_done)
    );

    assign m_data  = sel ? b_data  : {4'h0, a_data};
    assign m_valid = sel ? b_valid : a_valid;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] dchr(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : 8'h3F;
    endfunction

    task automatic push_b(input logic [7:0] b);
        exp_q.push_back({4'h0, b});
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push_b(s[i]);
    endtask

    task automatic push_num(input int id, input int fd, input logic [11:0] v, input logic [3:0] f);
        logic       lead;
        logic [3:0] nib;
        lead = 1'b1;
        for (int p = 0; p < id; p++) begin
            nib  = v[4*(id-1-p) +: 4];
            lead = lead && (nib == 4'd0);
`ifdef DHT_FMT_ZERO_SUPPRESS_EN
            if (lead && p != id - 1) push_b(8'h20);
            else push_b(dchr(nib));
`else
            push_b(dchr(nib));
`endif
        end
        if (fd != 0) begin
            push_b(8'h2E);
            push_b(dchr(f));
        end
    endtask

    task automatic push_line(input int id, input int fd);
        push_str("temp: ");
        push_num(id, fd, tint, tf);
        push_b(8'h20);
        push_str("humi: ");
        push_num(id, fd, hum_int, hf);
        push_b(8'h09);
        if (err) begin push_b(8'h58); push_b(8'h58); end
        else begin push_b(8'h4F); push_b(8'h4B); end
        push_b(8'h0D);
        push_b(8'h0A);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stream invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid) check("busy_in_send", {31'b0, m_busy}, 32'd1);
            else check("data_zero_idle", 32'(m_data), 32'd0);
            if (m_valid && prev_valid && !prev_ready) check("stall_hold", 32'(m_data), 32'(prev_data));
            if (m_valid && !prev_valid) rise_cyc = cyc;
            if (m_valid && ready) begin
                check("byte_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check($sformatf("byte%0d", nbytes), 32'(m_data), 32'(exp_q.pop_front()));
                nbytes++;
                if (exp_q.size() == 0) lf_cyc = cyc;
            end
            if (m_done) begin
                done_cnt++;
                check("done_pulse_len", {31'b0, prev_done}, 32'd0);
            end
        end
        prev_valid = m_valid;
        prev_ready = ready;
        prev_done  = m_done;
        prev_data  = m_data;
    end

    // Starts a line (expectations already queued) and drives ready until o_done.
    task automatic run_line(input int mode, input int len, input bit poke);
        int d0;
        int k;
        d0 = done_cnt;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 400) begin
            ready = (mode == 1) ? k[0] : 1'b1;
            start = 1'b0;
            if (poke) begin
                if (k == 8) begin
                    tint = 12'h987; tf = 4'd1; hum_int = 12'h321; hf = 4'd2; err = ~err;
                    start = 1'b1;
                end
                if (m_valid && ready && exp_q.size() == 1) start = 1'b1;
                if (m_done) start = 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        ready = 1'b1;
        check("line_done", 32'(done_cnt - d0), 32'd1);
        check("line_span", 32'(lf_cyc - rise_cyc + 1), 32'(len));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (poke) begin
            repeat (4) @(posedge clk);
            #1;
            check("no_second_line", {31'b0, m_busy | m_valid}, 32'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, m_valid}, 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_busy", {31'b0, m_busy}, 32'd0);
        check("rst_done", {31'b0, m_done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal line, ready held high.
        tint = 12'h023; tf = 4'd5; hum_int = 12'h045; hf = 4'd0; err = 1'b0;
        push_line(2, 1);
        run_line(0, 26, 1'b0);

        // Error status with ready toggling from low.
        err = 1'b1;
        push_line(2, 1);
        run_line(1, 52, 1'b0);

        // Snapshot isolation and dropped starts, with leading zero and invalid fraction.
        tint = 12'h009; tf = 4'hA; hum_int = 12'h099; hf = 4'd9; err = 1'b0;
        push_line(2, 1);
        run_line(0, 26, 1'b1);

        // Asynchronous abort at byte 10, then a clean line.
        tint = 12'h031; tf = 4'd7; hum_int = 12'h062; hf = 4'd8; err = 1'b0;
        push_line(2, 1);
        n0 = nbytes;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100 && nbytes < n0 + 10; k++) @(posedge clk);
        check("reach_byte10", 32'(nbytes - n0), 32'd10);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'b0, m_valid}, 32'd0);
        check("abort_busy", {31'b0, m_busy}, 32'd0);
        check("abort_data", 32'(m_data), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_line(2, 1);
        run_line(0, 26, 1'b0);

        // Three integer digits, no fraction, 12-bit bytes.
        sel = 1'b1;
        @(posedge clk); #1;
        tint = 12'h007; tf = 4'd3; hum_int = 12'h050; hf = 4'd0; err = 1'b0;
        push_line(3, 0);
        run_line(0, 24, 1'b0);
        tint = 12'h0C0; hum_int = 12'h000; err = 1'b1;
        push_line(3, 0);
        run_line(1, 48, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dht_line_formatter.md
# dht_line_formatter

Parametrised successor to the fixed 26-character DHT status-line generator. On a start pulse it snapshots the BCD temperature and humidity digits and the sensor error flag. It then emits one ASCII line, `temp: TT.T humi: HH.H<TAB>OK<CR><LF>`, as a byte stream to the UART transmitter over a valid/ready handshake. The integer and fractional digit counts are configurable.

## Interface
- DATA_WIDTH, 8, output byte width; must be ≥ 8, upper bits zero.
- INT_DIGITS, 2, integer digits per value; legal range 1..3.
- FRAC_DIGITS, 1, fractional digits per value; legal range 0..1. When 0, the '.' and fraction character are omitted.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- i_start  in  1  single-cycle request to emit one line.
- i_error  in  1  sensor error flag, sampled at start.
- i_temp_int  in  4*INT_DIGITS  temperature integer BCD, most significant digit in the top nibble.
- i_temp_frac  in  4  temperature fraction BCD.
- i_humi_int  in  4*INT_DIGITS  humidity integer BCD.
- i_humi_frac  in  4  humidity fraction BCD.
- o_data  out  DATA_WIDTH  current character.
- o_valid  out  1  o_data holds a character.
- i_ready  in  1  downstream accepts the byte when o_valid && i_ready.
- o_busy  out  1  a line is in progress.
- o_done  out  1  one-cycle pulse after the LF byte is accepted.

## Operation
- Line layout, in order:
  - "temp: "
  - temperature integer digits, then ('.' and fraction digit) if FRAC_DIGITS=1
  - ' '
  - "humi: "
  - humidity integer digits, then ('.' and fraction digit) if FRAC_DIGITS=1
  - 8'h09
  - status pair: "OK" (4F,4B), or "XX" (58,58) when the snapshot error flag is set
  - 8'h0D, 8'h0A
- Line length L = 18 + 2*INT_DIGITS + 4*FRAC_DIGITS (26 at the defaults).
- Digit mapping: 0..9 map to 8'h30+d. Nibbles A..F map to '?' (8'h3F).
- FSM states:
  - IDLE: on i_start, register all digit inputs and i_error, set index = 0, go to SEND.
  - SEND: o_valid=1. On handshake: if index = L-1, go to DONE; otherwise index++.
  - DONE: o_done=1 for one cycle, then go to IDLE.
- o_busy=1 in SEND and DONE.
- Inputs are used only from the snapshot. Input changes during a line have no effect on that line.
- i_start is ignored outside IDLE. There is no queuing.

## Timing
- Reset values: o_valid=0, o_data=0, o_busy=0, o_done=0, index=0, state IDLE.
- i_start sampled high at edge N → o_valid=1 with 't' from N+1.
- Throughput is one byte per cycle while i_ready is held high. An L-byte line completes L cycles after o_valid rises.
- While o_valid && !i_ready, o_data is held stable and never changes.
- o_data is 0 whenever o_valid=0.
- LF accepted at edge M → o_done=1 during cycle M+1; IDLE at M+2. The earliest next start is sampled at edge M+2.
- A start coincident with the LF handshake, or during DONE, is dropped.
- rst_n asserted mid-line aborts immediately. All outputs return to their reset values; no partial-line recovery.

## Configuration
- DHT_FMT_ZERO_SUPPRESS_EN defined: leading zero integer digits become ' ' (8'h20). Suppression stops at the first nonzero digit. The least significant integer digit is always printed. '?' digits are never suppressed.
- DHT_FMT_ZERO_SUPPRESS_EN undefined: every digit is printed literally. Line length is identical in both builds.

## Structure
- Package dht_fmt_pkg holds:
  - ASCII constants: t e m p h u i : space . TAB CR LF O K X ?
  - state enum {IDLE, SEND, DONE}
  - line-length function of INT_DIGITS and FRAC_DIGITS
- Sub-module bcd_to_ascii: 4-bit nibble in, 8-bit ASCII out, '?' for invalid nibbles. Instantiated once per snapshot digit.
- Character selection is a case on index, built from parameter-derived field offsets. There is no hard-coded per-index list.

## Test plan
- Defaults; temp 2_3.5, humi 4_5.0, error=0; ready always 1 → 26 bytes "temp: 23.5 humi: 45.0\tOK\r\n" on consecutive cycles; o_done once.
- Same line with error=1 and ready toggling 1/0 every cycle → bytes 23,24 are 58,58. o_data is stable during every stall. The line takes 52 cycles.
- Inputs changed and i_start pulsed mid-line → the emitted line matches the original snapshot; the extra start produces no second line.
- INT_DIGITS=3, FRAC_DIGITS=0; temp 0_0_7 → L=24. With the macro defined: "  7". Without it: "007". A temp nibble of C gives '?'.
- rst_n asserted at byte 10 → o_valid=0 and o_busy=0 asynchronously. After release, a new start emits a full line starting with 't'.
